// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control unit for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared req/ready memory port,
// traps on illegal opcodes and on memory requests that are never answered.
// Optional feature: define MC_RETIRE_CNT_EN to build the retired-instruction
// counter; without it the retired port is tied to zero and has no flops.
module multicycle_controller #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             alu_src,
    output logic [3:0]       alu_cc,
    output logic             reg_write,
    output logic             mem2reg,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] CC_AND = 4'b0000;
    localparam logic [3:0] CC_OR  = 4'b0001;
    localparam logic [3:0] CC_ADD = 4'b0010;
    localparam logic [3:0] CC_XOR = 4'b0011;
    localparam logic [3:0] CC_SUB = 4'b0110;
    localparam logic [3:0] CC_SLT = 4'b0111;

    state_t            cur;
    logic [WAIT_W-1:0] waitCnt;

    logic isR, isI, isLoad, isStore, isBranch, legal;
    logic [3:0] aluCode;
    logic       aluOk;

    assign isR      = (opcode == 7'b0110011);
    assign isI      = (opcode == 7'b0010011);
    assign isLoad   = (opcode == 7'b0000011);
    assign isStore  = (opcode == 7'b0100011);
    assign isBranch = (opcode == 7'b1100011);
    assign legal    = isR | isI | isLoad | isStore | isBranch;

    // ALU operation from funct3/funct7; R-type only accepts funct7 of
    // 0000000, or 0100000 together with funct3=000 (SUB). I-type ignores funct7.
    always_comb begin
        aluCode = CC_ADD;
        aluOk   = 1'b1;
        case (funct3)
            3'b000:  aluCode = (isR && funct7[5]) ? CC_SUB : CC_ADD;
            3'b111:  aluCode = CC_AND;
            3'b110:  aluCode = CC_OR;
            3'b100:  aluCode = CC_XOR;
            3'b010:  aluCode = CC_SLT;
            default: aluOk   = 1'b0;
        endcase
        if (isR) begin
            if (funct7[6] || (funct7[4:0] != 5'd0)) begin
                aluOk = 1'b0;
            end
            if (funct7[5] && (funct3 != 3'b000)) begin
                aluOk = 1'b0;
            end
        end
    end

    // State register and memory wait counter; the counter only runs while a
    // request is outstanding and is cleared whenever the state moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur     <= FETCH;
            waitCnt <= '0;
        end else begin
            case (cur)
                FETCH: begin
                    if (mem_ready) begin
                        cur     <= DECODE;
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_MAX) begin
                        cur     <= TRAP;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DECODE: begin
                    cur <= legal ? EXEC : TRAP;
                end
                EXEC: begin
                    if (isR || isI) begin
                        cur <= aluOk ? WB : TRAP;
                    end else if (isLoad || isStore) begin
                        cur <= MEM;
                    end else if (isBranch) begin
                        cur <= FETCH;
                    end else begin
                        cur <= TRAP;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        cur     <= isStore ? FETCH : WB;
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_MAX) begin
                        cur     <= TRAP;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                WB: begin
                    cur <= FETCH;
                end
                TRAP: begin
                    cur <= TRAP;
                end
                default: begin
                    cur <= TRAP;
                end
            endcase
        end
    end

    // Control outputs decoded from the current state; PC/IR load in FETCH is
    // qualified by the handshake so they fire only in the completing cycle.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        addr_sel  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_src   = 1'b0;
        alu_cc    = 4'b0000;
        reg_write = 1'b0;
        mem2reg   = 1'b0;
        trap      = 1'b0;
        case (cur)
            FETCH: begin
                mem_req  = 1'b1;
                pc_write = mem_ready;
                ir_write = mem_ready;
            end
            EXEC: begin
                if (isR) begin
                    alu_cc = aluCode;
                end else if (isI) begin
                    alu_src = 1'b1;
                    alu_cc  = aluCode;
                end else if (isLoad || isStore) begin
                    alu_src = 1'b1;
                    alu_cc  = CC_ADD;
                end else if (isBranch) begin
                    alu_cc   = CC_SUB;
                    pc_write = zero;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = isStore;
            end
            WB: begin
                reg_write = 1'b1;
                mem2reg   = isLoad;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

    assign state = cur;

`ifdef MC_RETIRE_CNT_EN
    logic [CNT_W-1:0] retCnt;
    logic             retireEvt;

    assign retireEvt = (cur == WB)
                     || ((cur == MEM) && isStore && mem_ready)
                     || ((cur == EXEC) && isBranch);

    // Retired-instruction counter, bumped on every return to FETCH that ends
    // an instruction; it wraps naturally and stops once the FSM traps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retCnt <= '0;
        end else if (retireEvt) begin
            retCnt <= retCnt + 1'b1;
        end
    end

    assign retired = retCnt;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed stimulus with a scoreboard queue.
// The stimulus side pushes the hand-computed outputs for every cycle; a
// separate monitor pops and compares them mid-cycle.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;
    localparam int CW      = 4;

`ifdef MC_RETIRE_CNT_EN
    localparam bit RETIRE_ON = 1'b1;
`else
    localparam bit RETIRE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic [6:0]    funct7 = 7'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, ir_write, addr_sel, mem_req, mem_we, alu_src;
    logic [3:0]    alu_cc;
    logic          reg_write, mem2reg, trap;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    typedef struct {
        string         name;
        logic [15:0]   outs;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sbq[$];
    logic [CW-1:0] expRetired = '0;
    int            assertCount = 0;
    int            failCount = 0;

    multicycle_controller #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .addr_sel(addr_sel),
        .mem_req(mem_req), .mem_we(mem_we), .alu_src(alu_src),
        .alu_cc(alu_cc), .reg_write(reg_write), .mem2reg(mem2reg),
        .state(state), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    // Output vector: {state, pc_write, ir_write, addr_sel, mem_req, mem_we,
    // alu_src, alu_cc, reg_write, mem2reg, trap}.
    function automatic logic [15:0] ov(input int st, input int pcw, input int irw,
                                       input int asel, input int req, input int we,
                                       input int asrc, input int cc, input int rw,
                                       input int m2r, input int tr);
        return {3'(st), 1'(pcw), 1'(irw), 1'(asel), 1'(req), 1'(we), 1'(asrc),
                4'(cc), 1'(rw), 1'(m2r), 1'(tr)};
    endfunction

    task automatic applyStimulus(input string name, input int rst, input int rdy,
                                 input int z, input logic [15:0] outs, input int ret);
        exp_t e;
        @(negedge clk);
        reset     = 1'(rst);
        mem_ready = 1'(rdy);
        zero      = 1'(z);
        if (rst == 0) expRetired = '0;
        e.name = name;
        e.outs = outs;
        e.ret  = expRetired;
        sbq.push_back(e);
        if (RETIRE_ON && ret != 0 && rst != 0) expRetired = expRetired + 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [15:0] act;
        act = {state, pc_write, ir_write, addr_sel, mem_req, mem_we, alu_src,
               alu_cc, reg_write, mem2reg, trap};
        assertCount++;
        if (act !== e.outs || retired !== e.ret) begin
            failCount++;
            $display("[TB] FAIL %s: got outs=%b retired=%0d, expected outs=%b retired=%0d",
                     e.name, act, retired, e.outs, e.ret);
        end
    endtask

    task automatic fetchInstr(input string name, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7);
        applyStimulus({name, "/fetch"}, 1, 1, 0, ov(0,1,1,0,1,0,0,0,0,0,0), 0);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic decodeCycle(input string name);
        applyStimulus({name, "/decode"}, 1, 1, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0);
    endtask

    task automatic wbCycle(input string name, input int isLoad);
        applyStimulus({name, "/wb"}, 1, 1, 0, ov(4,0,0,0,0,0,0,0,1,isLoad,0), 1);
    endtask

    task automatic branchInstr(input string name, input int z);
        fetchInstr(name, 7'b1100011, 3'b000, 7'b0000000);
        decodeCycle(name);
        applyStimulus({name, "/exec"}, 1, 1, z, ov(2,z,0,0,0,0,0,4'b0110,0,0,0), 1);
    endtask

    // Monitor: compare one scoreboard entry per cycle, away from the edges.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) checkOutput(sbq.pop_front());
        end
    end

    logic [2:0] rF3 [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    logic [6:0] rF7 [5] = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    int         rCc [5] = '{6, 0, 1, 3, 7};

    initial begin
        logic [15:0] fWait, trapV, memRd;
        fWait = ov(0,0,0,0,1,0,0,0,0,0,0);
        trapV = ov(7,0,0,0,0,0,0,0,0,0,1);
        memRd = ov(3,0,0,1,1,0,0,0,0,0,0);

        applyStimulus("reset0", 0, 0, 0, fWait, 0);
        applyStimulus("reset1", 0, 0, 0, fWait, 0);

        fetchInstr("add", 7'b0110011, 3'b000, 7'b0000000);
        decodeCycle("add");
        applyStimulus("add/exec", 1, 1, 0, ov(2,0,0,0,0,0,0,4'b0010,0,0,0), 0);
        wbCycle("add", 0);

        for (int i = 0; i < 5; i++) begin
            fetchInstr("rop", 7'b0110011, rF3[i], rF7[i]);
            decodeCycle("rop");
            applyStimulus("rop/exec", 1, 1, 0, ov(2,0,0,0,0,0,0,rCc[i],0,0,0), 0);
            wbCycle("rop", 0);
        end

        fetchInstr("addi", 7'b0010011, 3'b000, 7'b0100000);
        decodeCycle("addi");
        applyStimulus("addi/exec", 1, 1, 0, ov(2,0,0,0,0,0,1,4'b0010,0,0,0), 0);
        wbCycle("addi", 0);

        fetchInstr("ori", 7'b0010011, 3'b110, 7'b0000000);
        decodeCycle("ori");
        applyStimulus("ori/exec", 1, 1, 0, ov(2,0,0,0,0,0,1,4'b0001,0,0,0), 0);
        wbCycle("ori", 0);

        fetchInstr("load", 7'b0000011, 3'b010, 7'b0000000);
        decodeCycle("load");
        applyStimulus("load/exec", 1, 0, 0, ov(2,0,0,0,0,0,1,4'b0010,0,0,0), 0);
        for (int i = 0; i < 3; i++) applyStimulus("load/memWait", 1, 0, 0, memRd, 0);
        applyStimulus("load/memDone", 1, 1, 0, memRd, 0);
        wbCycle("load", 1);

        fetchInstr("store", 7'b0100011, 3'b010, 7'b0000000);
        decodeCycle("store");
        applyStimulus("store/exec", 1, 1, 0, ov(2,0,0,0,0,0,1,4'b0010,0,0,0), 0);
        applyStimulus("store/mem", 1, 1, 0, ov(3,0,0,1,1,1,0,0,0,0,0), 1);

        branchInstr("beqTaken", 1);
        branchInstr("beqNotTaken", 0);

        applyStimulus("resetForCount", 0, 0, 0, fWait, 0);
        for (int i = 0; i < 17; i++) branchInstr("beqCount", i % 2);

        for (int i = 0; i < 15; i++) applyStimulus("fetchLateWait", 1, 0, 0, fWait, 0);
        fetchInstr("lateAdd", 7'b0110011, 3'b000, 7'b0000000);
        decodeCycle("lateAdd");
        applyStimulus("lateAdd/exec", 1, 1, 0, ov(2,0,0,0,0,0,0,4'b0010,0,0,0), 0);
        wbCycle("lateAdd", 0);

        for (int i = 0; i < 16; i++) applyStimulus("fetchTimeout", 1, 0, 0, fWait, 0);
        for (int i = 0; i < 4; i++) applyStimulus("trapHold", 1, i % 2, 0, trapV, 0);
        applyStimulus("resetFromTrap", 0, 0, 0, fWait, 0);

        fetchInstr("illegal", 7'b1111111, 3'b000, 7'b0000000);
        decodeCycle("illegal");
        for (int i = 0; i < 4; i++) applyStimulus("illegalTrap", 1, 1 - (i % 2), 0, trapV, 0);
        applyStimulus("resetFromIllegal", 0, 0, 0, fWait, 0);

        fetchInstr("memTo", 7'b0000011, 3'b000, 7'b0000000);
        decodeCycle("memTo");
        applyStimulus("memTo/exec", 1, 0, 0, ov(2,0,0,0,0,0,1,4'b0010,0,0,0), 0);
        for (int i = 0; i < 16; i++) applyStimulus("memTo/wait", 1, 0, 0, memRd, 0);
        applyStimulus("memTo/trap", 1, 1, 0, trapV, 0);
        applyStimulus("resetFromMemTo", 0, 0, 0, fWait, 0);

        fetchInstr("addAfter", 7'b0110011, 3'b000, 7'b0000000);
        decodeCycle("addAfter");
        applyStimulus("addAfter/exec", 1, 1, 0, ov(2,0,0,0,0,0,0,4'b0010,0,0,0), 0);
        wbCycle("addAfter", 0);

        fetchInstr("midMem", 7'b0000011, 3'b000, 7'b0000000);
        decodeCycle("midMem");
        applyStimulus("midMem/exec", 1, 0, 0, ov(2,0,0,0,0,0,1,4'b0010,0,0,0), 0);
        applyStimulus("midMem/wait", 1, 0, 0, memRd, 0);
        applyStimulus("midMem/wait", 1, 0, 0, memRd, 0);
        applyStimulus("resetMidMem", 0, 0, 0, fWait, 0);
        applyStimulus("afterReset", 1, 0, 0, fWait, 0);

        @(negedge clk);
        #3;
        assertCount++;
        if (sbq.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboardDrain: got %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
